hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised scoreboard hazard unit for the pipelined MIPS core. Replaces fixed EXE/MEM dest compares.
//  Keeps per-register countdowns for multi-cycle producers such as MUL/DIV.
//  Sits beside ID; drives the IF/ID stall and the ID->EX bubble.
//  Detects RAW (forward-aware), ID-resolved branch RAW, WAW ordering and writeback-port collisions.
// PARAMETERS
//  REG_ADDR_W  5   register address width
//  NUM_REGS    32  architectural registers tracked (reg 0 never tracked)
//  LAT_W       4   width of latency inputs/counters (max latency 2**LAT_W-1)
// PORTS
//  clk          in   1           core clock
//  rst          in   1           async active-high reset
//  id_valid     in   1           valid instruction in ID
//  id_rs        in   REG_ADDR_W  source 1
//  id_rt        in   REG_ADDR_W  source 2
//  id_rt_used   in   1           rt is a real source (~is_imm | store | BNE)
//  id_is_branch in   1           branch compared in ID (COND_BEZ/COND_BNE)
//  id_wb_en     in   1           instruction writes a register
//  id_dest      in   REG_ADDR_W  destination register
//  id_fwd_lat   in   LAT_W       cycles from issue until result is forwardable to EX (ALU 1, load 2)
//  id_wb_lat    in   LAT_W       cycles from issue until WB stage (5-stage ALU/load 3; MUL 3+k)
//  flush        in   1           squash instruction in ID this cycle
//  stall        out  1           hold PC and IF/ID; insert bubble into EX
//  issue        out  1           id_valid & ~stall & ~flush
//  hazard_cause out  3           {port, waw, raw}; raw covers branch RAW
//  busy_vec     out  NUM_REGS    bit r = wb_cnt[r] != 0
// BEHAVIOUR
//  - State per reg r (1..NUM_REGS-1): fwd_cnt[r], wb_cnt[r]. Reset clears all; reg 0 entry is constant 0.
//  - Each clk: if issue & id_wb_en & id_dest!=0, load fwd_cnt[id_dest]=id_fwd_lat, wb_cnt[id_dest]=id_wb_lat.
//    Every other entry decrements and saturates at 0.
//  - Stall and issue are combinational from current counters and ID inputs. The issuing instruction
//    checks old counters; its own dest update is visible next cycle.
//  - raw (non-branch): (fwd_cnt[rs]>1) | (id_rt_used & fwd_cnt[rt]>1).
//  - raw (branch): (wb_cnt[rs]>1) | (id_rt_used & wb_cnt[rt]>1). Register file is write-first, so
//    WB-stage data is usable in ID.
//  - waw: id_wb_en & id_dest!=0 & wb_cnt[id_dest] > id_wb_lat. A younger short op must not retire before an older long op.
//  - port: id_wb_en & some r has wb_cnt[r]==id_wb_lat. Single regfile write port.
//  - stall = id_valid & ~flush & (raw|waw|port). hazard_cause is valid only while stall=1, else 0.
//  - flush has priority over stall. A flushed instruction never updates counters.
//    In-flight producers keep counting down.
//  - Latency 0 on an issuing writer is treated as 1.
//  - Reset mid-operation clears all pending state immediately. Outputs after reset: stall=0, issue=id_valid&~flush,
//    hazard_cause=0, busy_vec=0.
//  - Worst case: a branch behind a MUL stalls until MUL wb_cnt reaches 1, then issues.
// CONFIGURATION
//  - Macro HAZARD_PERF_CNT_EN defined: adds outputs perf_raw_cnt, perf_br_cnt, perf_struct_cnt (32 each).
//    Each increments once per stalled cycle of its class (struct = waw|port; raw split by id_is_branch).
//    Counters wrap at 2**32, cleared by rst.
//  - Macro undefined: counters and ports absent. Functional behaviour identical.
// STRUCTURE
//  - defines.v: REG_FILE_ADDR_LEN, COND_BEZ/COND_BNE, LAT_ALU_FWD=1, LAT_LOAD_FWD=2, LAT_WB_BASE=3,
//    hazard_cause bit indices.
//  - Sub-module sb_reg_entry holds one register's fwd/wb counter pair with load/decrement/saturate.
//    Exports fwd_cnt, wb_cnt and busy. Instantiate NUM_REGS-1 times via generate.
//  - Top: source/dest muxing of entries, latency-match reduction for port check, stall logic.
// TESTING
//  - ALU r3 (fwd1,wb3) then ADD rs=r3 next cycle -> stall=0, issue=1 (forwarded).
//  - LW r5 (fwd2,wb3) then ADD rt=r5, rt_used=1 -> one stall cycle, cause=001, then issue.
//    Same with rt_used=0 -> no stall.
//  - ALU r4 then BEQ rs=r4 -> stalls 2 cycles (wb_cnt 3,2), issues when wb_cnt=1.
//    Also: same BEQ with flush=1 -> stall=0, issue=0.
//  - MUL r6 (fwd6,wb6); next cycle ADD r6 (wb3) -> waw stall until wb_cnt[r6]<=3.
//    ADD r7 (wb3) issued when MUL wb_cnt=3 -> port stall, cause=100.
//  - Async rst asserted mid-MUL with busy_vec!=0 -> busy_vec=0, stall=0 without a clock edge.
//    A dependent ADD then issues immediately.
//  - With HAZARD_PERF_CNT_EN: LW+use x4 -> perf_raw_cnt=4, perf_br_cnt=0, perf_struct_cnt=0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the scoreboard hazard unit.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
package hazard_scoreboard_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_LAT_W      = 4;

    localparam int LAT_ALU_FWD  = 1;
    localparam int LAT_LOAD_FWD = 2;
    localparam int LAT_WB_BASE  = 3;

    localparam int CAUSE_RAW  = 0;
    localparam int CAUSE_WAW  = 1;
    localparam int CAUSE_PORT = 2;

    typedef struct packed {
        logic port;
        logic waw;
        logic raw;
    } hazard_cause_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> scoreboard bundle; perf counter signals exist only with HAZARD_PERF_CNT_EN.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int LAT_W      = DEF_LAT_W
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_rt_used;
    logic                  id_is_branch;
    logic                  id_wb_en;
    logic [REG_ADDR_W-1:0] id_dest;
    logic [LAT_W-1:0]      id_fwd_lat;
    logic [LAT_W-1:0]      id_wb_lat;
    logic                  flush;
    logic                  stall;
    logic                  issue;
    hazard_cause_t         hazard_cause;
    logic [NUM_REGS-1:0]   busy_vec;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]           perf_raw_cnt;
    logic [31:0]           perf_br_cnt;
    logic [31:0]           perf_struct_cnt;
`endif

    modport master (
        output id_valid, id_rs, id_rt, id_rt_used, id_is_branch,
        output id_wb_en, id_dest, id_fwd_lat, id_wb_lat, flush,
`ifdef HAZARD_PERF_CNT_EN
        input  perf_raw_cnt, perf_br_cnt, perf_struct_cnt,
`endif
        input  stall, issue, hazard_cause, busy_vec
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rt_used, id_is_branch,
        input  id_wb_en, id_dest, id_fwd_lat, id_wb_lat, flush,
`ifdef HAZARD_PERF_CNT_EN
        output perf_raw_cnt, perf_br_cnt, perf_struct_cnt,
`endif
        output stall, issue, hazard_cause, busy_vec
    );

endinterface

// File: rtl/hazard_scoreboard_sb_reg_entry.sv
// One architectural register's forward/writeback countdown pair.
module hazard_scoreboard_sb_reg_entry #(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LAT_W-1:0] fwd_lat_i,
    input  logic [LAT_W-1:0] wb_lat_i,
    output logic [LAT_W-1:0] fwd_cnt_o,
    output logic [LAT_W-1:0] wb_cnt_o,
    output logic             busy_o
);
    logic [LAT_W-1:0] fwd_q, fwd_d;
    logic [LAT_W-1:0] wb_q, wb_d;

    // Reload on a new writer, otherwise count down and rest at zero.
    always_comb begin
        fwd_d = fwd_q;
        wb_d  = wb_q;
        if (load_i) begin
            fwd_d = fwd_lat_i;
            wb_d  = wb_lat_i;
        end else begin
            fwd_d = (fwd_q != '0) ? fwd_q - LAT_W'(1) : fwd_q;
            wb_d  = (wb_q != '0) ? wb_q - LAT_W'(1) : wb_q;
        end
    end

    // Counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_q <= '0;
            wb_q  <= '0;
        end else begin
            fwd_q <= fwd_d;
            wb_q  <= wb_d;
        end
    end

    assign fwd_cnt_o = fwd_q;
    assign wb_cnt_o  = wb_q;
    assign busy_o    = (wb_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit beside ID: RAW/branch-RAW, WAW and writeback-port checks.
// Define HAZARD_PERF_CNT_EN to add per-class stall counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int LAT_W      = DEF_LAT_W
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  sb
);
    function automatic logic [LAT_W-1:0] lat_floor1(input logic [LAT_W-1:0] lat);
        return (lat == '0) ? LAT_W'(1) : lat;
    endfunction

    logic [LAT_W-1:0]    fwd_cnt_s [1:NUM_REGS-1];
    logic [LAT_W-1:0]    wb_cnt_s  [1:NUM_REGS-1];
    logic                busy_s    [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] load_s, lat_match_s, busy_vec_s;
    logic [LAT_W-1:0]    fwd_lat_s, wb_lat_s;
    logic [LAT_W-1:0]    rs_fwd_s, rt_fwd_s, rs_wb_s, rt_wb_s, dest_wb_s;
    logic                raw_s, waw_s, port_s, stall_s, issue_s;
    hazard_cause_t       cause_s;

    assign fwd_lat_s = lat_floor1(sb.id_fwd_lat);
    assign wb_lat_s  = lat_floor1(sb.id_wb_lat);

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        hazard_scoreboard_sb_reg_entry #(.LAT_W(LAT_W)) u_entry (
            .clk       (clk),
            .rst       (rst),
            .load_i    (load_s[r]),
            .fwd_lat_i (fwd_lat_s),
            .wb_lat_i  (wb_lat_s),
            .fwd_cnt_o (fwd_cnt_s[r]),
            .wb_cnt_o  (wb_cnt_s[r]),
            .busy_o    (busy_s[r])
        );
    end

    // Source/dest entry muxes; register 0 has no entry and reads as idle.
    always_comb begin
        rs_fwd_s    = '0;
        rt_fwd_s    = '0;
        rs_wb_s     = '0;
        rt_wb_s     = '0;
        dest_wb_s   = '0;
        lat_match_s = '0;
        busy_vec_s  = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            rs_fwd_s       |= (sb.id_rs   == REG_ADDR_W'(r)) ? fwd_cnt_s[r] : '0;
            rt_fwd_s       |= (sb.id_rt   == REG_ADDR_W'(r)) ? fwd_cnt_s[r] : '0;
            rs_wb_s        |= (sb.id_rs   == REG_ADDR_W'(r)) ? wb_cnt_s[r]  : '0;
            rt_wb_s        |= (sb.id_rt   == REG_ADDR_W'(r)) ? wb_cnt_s[r]  : '0;
            dest_wb_s      |= (sb.id_dest == REG_ADDR_W'(r)) ? wb_cnt_s[r]  : '0;
            lat_match_s[r]  = (wb_cnt_s[r] == wb_lat_s);
            busy_vec_s[r]   = busy_s[r];
        end
    end

    // Hazard classification; branches read the write-first regfile so only WB counts matter.
    always_comb begin
        raw_s = 1'b0;
        if (sb.id_is_branch) begin
            raw_s = (rs_wb_s > LAT_W'(1)) | (sb.id_rt_used & (rt_wb_s > LAT_W'(1)));
        end else begin
            raw_s = (rs_fwd_s > LAT_W'(1)) | (sb.id_rt_used & (rt_fwd_s > LAT_W'(1)));
        end
        waw_s   = sb.id_wb_en & (sb.id_dest != '0) & (dest_wb_s > wb_lat_s);
        port_s  = sb.id_wb_en & (|lat_match_s);
        stall_s = sb.id_valid & ~sb.flush & (raw_s | waw_s | port_s);
        issue_s = sb.id_valid & ~sb.flush & ~stall_s;
        cause_s = '0;
        if (stall_s) begin
            cause_s = '{port: port_s, waw: waw_s, raw: raw_s};
        end else begin
            cause_s = '0;
        end
    end

    // Only an issuing writer to a real register reloads its entry.
    always_comb begin
        load_s = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            load_s[r] = issue_s & sb.id_wb_en & (sb.id_dest == REG_ADDR_W'(r));
        end
    end

    assign sb.stall        = stall_s;
    assign sb.issue        = issue_s;
    assign sb.hazard_cause = cause_s;
    assign sb.busy_vec     = busy_vec_s;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_raw_q, perf_raw_d;
    logic [31:0] perf_br_q, perf_br_d;
    logic [31:0] perf_struct_q, perf_struct_d;

    // One increment per stalled cycle for each class present; counters wrap.
    always_comb begin
        perf_raw_d    = perf_raw_q;
        perf_br_d     = perf_br_q;
        perf_struct_d = perf_struct_q;
        if (stall_s) begin
            perf_raw_d    = perf_raw_q + ((raw_s & ~sb.id_is_branch) ? 32'd1 : 32'd0);
            perf_br_d     = perf_br_q + ((raw_s & sb.id_is_branch) ? 32'd1 : 32'd0);
            perf_struct_d = perf_struct_q + ((waw_s | port_s) ? 32'd1 : 32'd0);
        end else begin
            perf_raw_d    = perf_raw_q;
            perf_br_d     = perf_br_q;
            perf_struct_d = perf_struct_q;
        end
    end

    // Counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_raw_q    <= 32'd0;
            perf_br_q     <= 32'd0;
            perf_struct_q <= 32'd0;
        end else begin
            perf_raw_q    <= perf_raw_d;
            perf_br_q     <= perf_br_d;
            perf_struct_q <= perf_struct_d;
        end
    end

    assign sb.perf_raw_cnt    = perf_raw_q;
    assign sb.perf_br_cnt     = perf_br_q;
    assign sb.perf_struct_cnt = perf_struct_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a timestamp-based reference model.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NR = DEF_NUM_REGS;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   now      = 0;
    int   fwd_t [NR];
    int   wb_t  [NR];

    hazard_scoreboard_if sb_if ();

    hazard_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) now <= now + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each register remembers the absolute cycles at which its newest
    // writer becomes forwardable and reaches writeback; remaining = deadline - now.
    always @(negedge clk) begin
        int rf [NR];
        int rw [NR];
        int ef, ew, rs, rt, dst;
        logic e_raw, e_waw, e_port, e_stall, e_issue;
        logic [2:0] e_cause;
        logic [31:0] e_busy;
        for (int i = 0; i < NR; i++) begin
            rf[i] = (rst || i == 0 || fwd_t[i] <= now) ? 0 : fwd_t[i] - now;
            rw[i] = (rst || i == 0 || wb_t[i] <= now) ? 0 : wb_t[i] - now;
        end
        rs  = int'(sb_if.id_rs);
        rt  = int'(sb_if.id_rt);
        dst = int'(sb_if.id_dest);
        ef  = (sb_if.id_fwd_lat == 4'd0) ? 1 : int'(sb_if.id_fwd_lat);
        ew  = (sb_if.id_wb_lat == 4'd0) ? 1 : int'(sb_if.id_wb_lat);
        if (sb_if.id_is_branch)
            e_raw = (rw[rs] > 1) || (sb_if.id_rt_used && rw[rt] > 1);
        else
            e_raw = (rf[rs] > 1) || (sb_if.id_rt_used && rf[rt] > 1);
        e_waw  = sb_if.id_wb_en && dst != 0 && rw[dst] > ew;
        e_port = 1'b0;
        e_busy = 32'd0;
        for (int i = 1; i < NR; i++) begin
            if (sb_if.id_wb_en && rw[i] == ew) e_port = 1'b1;
            e_busy[i] = (rw[i] != 0);
        end
        e_stall = sb_if.id_valid && !sb_if.flush && (e_raw || e_waw || e_port);
        e_issue = sb_if.id_valid && !sb_if.flush && !e_stall;
        e_cause = e_stall ? {e_port, e_waw, e_raw} : 3'b000;
        chk("m_stall", 32'(sb_if.stall), 32'(e_stall));
        chk("m_issue", 32'(sb_if.issue), 32'(e_issue));
        chk("m_cause", 32'(sb_if.hazard_cause), 32'(e_cause));
        chk("m_busy",  sb_if.busy_vec, e_busy);
        for (int i = 0; i < NR; i++) begin
            if (rst) begin
                fwd_t[i] <= 0;
                wb_t[i]  <= 0;
            end
        end
        if (!rst && e_issue && sb_if.id_wb_en && dst != 0) begin
            fwd_t[dst] <= now + 1 + ef;
            wb_t[dst]  <= now + 1 + ew;
        end
    end

    task automatic drive(input logic v, input int rs, input int rt, input logic used,
                         input logic br, input logic wen, input int dest,
                         input int fl, input int wl, input logic fsh);
        @(posedge clk);
        #1;
        sb_if.id_valid     = v;
        sb_if.id_rs        = 5'(rs);
        sb_if.id_rt        = 5'(rt);
        sb_if.id_rt_used   = used;
        sb_if.id_is_branch = br;
        sb_if.id_wb_en     = wen;
        sb_if.id_dest      = 5'(dest);
        sb_if.id_fwd_lat   = 4'(fl);
        sb_if.id_wb_lat    = 4'(wl);
        sb_if.flush        = fsh;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic lit(input string nm, input logic es, input logic ei, input logic [2:0] ec);
        #1;
        chk({nm, "_stall"}, 32'(sb_if.stall), 32'(es));
        chk({nm, "_issue"}, 32'(sb_if.issue), 32'(ei));
        chk({nm, "_cause"}, 32'(sb_if.hazard_cause), 32'(ec));
    endtask

    // Hold the current instruction until it issues; exp < 0 only guards the bound.
    task automatic hold(input string nm, input int max_cyc, input int exp);
        int n;
        n = 0;
        while (sb_if.issue !== 1'b1 && n < max_cyc) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp < 0) chk({nm, "_bound"}, 32'(n < max_cyc), 32'd1);
        else         chk({nm, "_stalls"}, 32'(n), 32'(exp));
    endtask

    int t_rs   [8] = '{1, 10, 11, 0, 12, 12, 0, 1};
    int t_rt   [8] = '{2, 0, 10, 0, 0, 13, 0, 12};
    int t_used [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int t_br   [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
    int t_wen  [8] = '{1, 1, 0, 1, 1, 0, 1, 1};
    int t_dest [8] = '{10, 11, 0, 12, 13, 0, 12, 0};
    int t_fl   [8] = '{0, 1, 1, 6, 1, 1, 2, 1};
    int t_wl   [8] = '{0, 3, 3, 9, 3, 3, 3, 3};

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sb_if.id_valid = 1'b0; sb_if.id_rs = 5'd0; sb_if.id_rt = 5'd0;
        sb_if.id_rt_used = 1'b0; sb_if.id_is_branch = 1'b0; sb_if.id_wb_en = 1'b0;
        sb_if.id_dest = 5'd0; sb_if.id_fwd_lat = 4'd0; sb_if.id_wb_lat = 4'd0;
        sb_if.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        idle(1);
        lit("reset_idle", 1'b0, 1'b0, 3'b000);
        chk("reset_busy", sb_if.busy_vec, 32'd0);

        // ALU result forwarded to the next instruction.
        drive(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 3, LAT_ALU_FWD, LAT_WB_BASE, 1'b0);
        lit("alu_r3", 1'b0, 1'b1, 3'b000);
        drive(1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 0, 1, 3, 1'b0);
        lit("add_fwd_r3", 1'b0, 1'b1, 3'b000);
        idle(4);

        // Load-use through rt: one bubble; rt unused: none.
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, LAT_LOAD_FWD, LAT_WB_BASE, 1'b0);
        lit("lw_r5", 1'b0, 1'b1, 3'b000);
        drive(1'b1, 1, 5, 1'b1, 1'b0, 1'b0, 0, 1, 3, 1'b0);
        lit("lw_use", 1'b1, 1'b0, 3'b001);
        hold("lw_use", 10, 1);
        idle(4);
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, LAT_LOAD_FWD, LAT_WB_BASE, 1'b0);
        drive(1'b1, 1, 5, 1'b0, 1'b0, 1'b0, 0, 1, 3, 1'b0);
        lit("lw_rt_unused", 1'b0, 1'b1, 3'b000);
        idle(4);

        // Branch in ID waits for writeback; flush overrides.
        drive(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 4, LAT_ALU_FWD, LAT_WB_BASE, 1'b0);
        drive(1'b1, 4, 0, 1'b0, 1'b1, 1'b0, 0, 1, 3, 1'b0);
        lit("beq_raw", 1'b1, 1'b0, 3'b001);
        hold("beq", 10, 2);
        idle(4);
        drive(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 4, LAT_ALU_FWD, LAT_WB_BASE, 1'b0);
        drive(1'b1, 4, 0, 1'b0, 1'b1, 1'b0, 0, 1, 3, 1'b1);
        lit("beq_flush", 1'b0, 1'b0, 3'b000);
        idle(4);

        // MUL then short writer to the same register: waw, then port at wb_cnt=3.
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 6, 6, 6, 1'b0);
        drive(1'b1, 1, 2, 1'b0, 1'b0, 1'b1, 6, 1, 3, 1'b0);
        lit("waw", 1'b1, 1'b0, 3'b010);
        hold("waw", 12, 4);
        idle(8);

        // Unrelated short writer meeting the MUL on the write port.
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 6, 6, 6, 1'b0);
        idle(3);
        #1 chk("busy_mul", sb_if.busy_vec, 32'h0000_0040);
        drive(1'b1, 1, 2, 1'b0, 1'b0, 1'b1, 7, 1, 3, 1'b0);
        lit("port", 1'b1, 1'b0, 3'b100);
        hold("port", 10, 1);
        idle(8);

        // Asynchronous reset in the middle of a MUL.
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 6, 6, 6, 1'b0);
        drive(1'b1, 6, 0, 1'b0, 1'b0, 1'b0, 0, 1, 3, 1'b0);
        lit("mul_use", 1'b1, 1'b0, 3'b001);
        chk("mul_busy", sb_if.busy_vec, 32'h0000_0040);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy",  sb_if.busy_vec, 32'd0);
        chk("arst_stall", 32'(sb_if.stall), 32'd0);
        chk("arst_issue", 32'(sb_if.issue), 32'd1);
        chk("arst_cause", 32'(sb_if.hazard_cause), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        lit("post_rst", 1'b0, 1'b1, 3'b000);
        idle(2);

        // Mixed sequence checked by the model, including zero latencies.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, t_rs[i], t_rt[i], 1'(t_used[i]), 1'(t_br[i]), 1'(t_wen[i]),
                  t_dest[i], t_fl[i], t_wl[i], 1'b0);
            hold($sformatf("tbl%0d", i), 20, -1);
        end
        idle(12);

`ifdef HAZARD_PERF_CNT_EN
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 20 + k, LAT_LOAD_FWD, LAT_WB_BASE, 1'b0);
            drive(1'b1, 1, 20 + k, 1'b1, 1'b0, 1'b0, 0, 1, 3, 1'b0);
            hold($sformatf("perf_use%0d", k), 10, 1);
        end
        chk("perf_raw",    sb_if.perf_raw_cnt,    32'd4);
        chk("perf_br",     sb_if.perf_br_cnt,     32'd0);
        chk("perf_struct", sb_if.perf_struct_cnt, 32'd0);
        idle(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
